mac_accum: RTL and testbench

- Downstream consumer of the 2-lane multiply-add pipeline; sums a programmed number of its 17-bit MultAdd results into a dot-product total.
- Tracks operand validity through a delay line matched to the upstream latency, because the multiply-add stage carries no valid signal.
- Presents the final sum on a valid/ready handshake to the next ALU stage.

---
 rtl/mac_accum_if.sv | 28 ++
 rtl/mac_accum.sv | 149 ++++++++++++++
 tb/tb_mac_accum.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accum_if.sv
// Handshake/bus bundle between the multiply-add pipeline, the accumulator
// and the next ALU stage. The accumulator uses the slave view; whatever
// drives it (upstream glue or a bench) uses the master view.
interface mac_accum_if #(
    parameter int IN_W  = 17,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
);
    logic             iSTART;      // start pulse; latches iLEN
    logic [LEN_W-1:0] iLEN;        // number of terms to accumulate
    logic             iOP_VALID;   // operands entering upstream this cycle
    logic [IN_W-1:0]  iMULTADD;    // upstream MultAdd result
    logic             oBUSY;       // job in RUN or DONE
    logic [ACC_W-1:0] oSUM;        // final sum, meaningful while oSUM_VALID
    logic             oSUM_VALID;  // sum available
    logic             iSUM_READY;  // consumer accepts sum
    logic             oOVF;        // saturation in current/last job

    modport slave (
        input  iSTART, iLEN, iOP_VALID, iMULTADD, iSUM_READY,
        output oBUSY, oSUM, oSUM_VALID, oOVF
    );

    modport master (
        output iSTART, iLEN, iOP_VALID, iMULTADD, iSUM_READY,
        input  oBUSY, oSUM, oSUM_VALID, oOVF
    );
endinterface

// File: rtl/mac_accum.sv
// Dot-product accumulator sitting behind the 2-lane multiply-add pipeline.
// The upstream stage has no valid output, so operand validity is carried
// through a PIPE_LAT-deep delay line that lines up with iMULTADD. A job sums
// iLEN results (unsigned, saturating) and offers the total on a valid/ready
// handshake.
module mac_accum #(
    parameter int IN_W     = 17,
    parameter int ACC_W    = 24,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    mac_accum_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [PIPE_LAT-1:0] dv_q;

    logic               op_gate;
    logic               dv;
    logic [ACC_W:0]     acc_sum;
    logic               acc_sat;

    // An op counts only while running and only up to the programmed length;
    // anything else never enters the delay line.
    assign op_gate = bus.iOP_VALID && (state_q == S_RUN) && (issued_q < len_q);
    assign dv      = dv_q[PIPE_LAT-1];

    // One extra bit catches carry-out for saturation.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.iMULTADD};
    assign acc_sat = acc_sum[ACC_W];

    // Validity delay line, matched to the upstream multiply-add latency.
    // NOTE: only this valid line needs a reset; the upstream product
    // registers are unreset, and a cleared line guarantees their power-up
    // or in-flight contents are never summed.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            dv_q <= '0;
        end else begin
            dv_q[0] <= op_gate;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dv_q[i] <= dv_q[i-1];
            end
        end
    end

    // Control and datapath state registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            len_q       <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
        end
    end

    // Next-state and datapath update for IDLE -> RUN -> DONE.
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;

        case (state_q)
            S_IDLE: begin
                // A zero-length start is meaningless and is dropped.
                if (bus.iSTART && (bus.iLEN != '0)) begin
                    state_d     = S_RUN;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    len_d       = bus.iLEN;
                    remaining_d = bus.iLEN;
                    issued_d    = '0;
                end
            end

            S_RUN: begin
                if (op_gate) begin
                    issued_d = issued_q + 1'b1;
                end
                if (dv) begin
                    if (acc_sat) begin
                        acc_d = ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_sum[ACC_W-1:0];
                    end
                    remaining_d = remaining_q - 1'b1;
                    // Last expected term: publish the updated total.
                    if (remaining_q == LEN_W'(1)) begin
                        sum_d   = acc_d;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                if (bus.iSUM_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    assign bus.oBUSY      = (state_q != S_IDLE);
    assign bus.oSUM_VALID = (state_q == S_DONE);
    assign bus.oSUM       = sum_q;
    assign bus.oOVF       = ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum. A small model of the upstream multiply-add
// pipeline delays the bench's chosen product by PIPE_LAT clocks onto
// iMULTADD and otherwise presents a garbage value, as the real unvalidated
// upstream would.
module tb_mac_accum;

    localparam int IN_W     = 17;
    localparam int ACC_W    = 24;
    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;
    localparam logic [IN_W-1:0] GARB = 17'h1F0F3;

    logic iCLK;
    logic iRST_N;

    int n_checks = 0;
    int n_err    = 0;

    logic [IN_W-1:0] prod_in;
    logic [IN_W-1:0] pipe [PIPE_LAT];

    mac_accum_if #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    mac_accum #(
        .IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .bus   (bus)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Upstream model: unreset product pipeline, no valid.
    always @(posedge iCLK) begin
        pipe[0] <= prod_in;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign bus.iMULTADD = pipe[PIPE_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic op(input logic [IN_W-1:0] p);
        bus.iOP_VALID = 1'b1;
        prod_in       = p;
        tick();
        bus.iOP_VALID = 1'b0;
        prod_in       = GARB;
    endtask

    task automatic start(input logic [LEN_W-1:0] len);
        bus.iSTART = 1'b1;
        bus.iLEN   = len;
        tick();
        bus.iSTART = 1'b0;
    endtask

    task automatic accept();
        bus.iSUM_READY = 1'b1;
        tick();
        bus.iSUM_READY = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!bus.oSUM_VALID && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(bus.oSUM_VALID), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRST_N         = 1'b0;
        bus.iSTART     = 1'b0;
        bus.iLEN       = '0;
        bus.iOP_VALID  = 1'b0;
        bus.iSUM_READY = 1'b0;
        prod_in        = GARB;

        // Reset state
        #12;
        chk("rst_busy",  32'(bus.oBUSY), 0);
        chk("rst_valid", 32'(bus.oSUM_VALID), 0);
        chk("rst_sum",   32'(bus.oSUM), 0);
        chk("rst_ovf",   32'(bus.oOVF), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        tick();

        // Job 1: four back-to-back terms, exact latency
        start(8'd4);
        chk("j1_busy", 32'(bus.oBUSY), 1);
        op(17'd100);
        op(17'd200);
        op(17'd300);
        op(17'd400);
        tick();
        tick();
        chk("j1_valid_early", 32'(bus.oSUM_VALID), 0);
        tick();
        chk("j1_valid_on_time", 32'(bus.oSUM_VALID), 1);
        chk("j1_sum", 32'(bus.oSUM), 1000);
        chk("j1_ovf", 32'(bus.oOVF), 0);
        accept();
        chk("j1_valid_after_ack", 32'(bus.oSUM_VALID), 0);
        chk("j1_busy_after_ack",  32'(bus.oBUSY), 0);

        // Job 2: gapped terms, surplus ops dropped
        start(8'd3);
        op(17'd130050);
        tick();
        tick();
        op(17'd130050);
        tick();
        tick();
        op(17'd130050);
        op(17'd1000);
        op(17'd1000);
        chk("j2_valid_early", 32'(bus.oSUM_VALID), 0);
        tick();
        chk("j2_valid", 32'(bus.oSUM_VALID), 1);
        chk("j2_sum", 32'(bus.oSUM), 390150);
        accept();

        // Follow-up job starts from a cleared accumulator
        start(8'd2);
        op(17'd40);
        op(17'd2);
        wait_valid("j3_timeout", 8);
        chk("j3_sum", 32'(bus.oSUM), 42);
        accept();

        // Job 4: 255 maximal terms saturate
        start(8'd255);
        for (int i = 0; i < 255; i++) begin
            op(17'd130050);
        end
        chk("j4_ovf_running", 32'(bus.oOVF), 1);
        wait_valid("j4_timeout", 10);
        chk("j4_sum", 32'(bus.oSUM), 16777215);
        chk("j4_ovf", 32'(bus.oOVF), 1);
        accept();

        // Job 5: overflow flag clears on the next start
        start(8'd1);
        chk("j5_ovf_cleared", 32'(bus.oOVF), 0);
        op(17'd5);
        wait_valid("j5_timeout", 8);
        chk("j5_sum", 32'(bus.oSUM), 5);
        chk("j5_ovf", 32'(bus.oOVF), 0);

        // Back-pressure: hold DONE while start/op toggle
        for (int i = 0; i < 10; i++) begin
            bus.iSTART    = i[0];
            bus.iLEN      = 8'd9;
            bus.iOP_VALID = ~i[0];
            prod_in       = 17'd777;
            tick();
            chk("bp_valid", 32'(bus.oSUM_VALID), 1);
            chk("bp_sum",   32'(bus.oSUM), 5);
            chk("bp_busy",  32'(bus.oBUSY), 1);
        end
        bus.iSTART    = 1'b0;
        bus.iOP_VALID = 1'b0;
        prod_in       = GARB;
        accept();
        chk("bp_busy_after_ack",  32'(bus.oBUSY), 0);
        chk("bp_valid_after_ack", 32'(bus.oSUM_VALID), 0);
        repeat (5) tick();
        chk("bp_no_new_job", 32'(bus.oBUSY), 0);

        // Zero-length start and ops in IDLE are ignored
        start(8'd0);
        chk("len0_busy", 32'(bus.oBUSY), 0);
        bus.iOP_VALID = 1'b1;
        repeat (4) tick();
        bus.iOP_VALID = 1'b0;
        chk("idle_ops_busy", 32'(bus.oBUSY), 0);
        bus.iSTART    = 1'b1;
        bus.iLEN      = 8'd1;
        bus.iOP_VALID = 1'b1;
        prod_in       = 17'd50000;
        tick();
        bus.iSTART    = 1'b0;
        bus.iOP_VALID = 1'b0;
        prod_in       = GARB;
        op(17'd11);
        wait_valid("j6_timeout", 8);
        chk("j6_sum", 32'(bus.oSUM), 11);
        accept();

        // Asynchronous reset mid-RUN after two of four terms
        start(8'd4);
        op(17'd1000);
        op(17'd2000);
        op(17'd3000);
        op(17'd4000);
        tick();
        #2;
        iRST_N = 1'b0;
        #1;
        chk("arst_busy",  32'(bus.oBUSY), 0);
        chk("arst_valid", 32'(bus.oSUM_VALID), 0);
        chk("arst_sum",   32'(bus.oSUM), 0);
        chk("arst_ovf",   32'(bus.oOVF), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        start(8'd2);
        op(17'd7);
        op(17'd9);
        wait_valid("j7_timeout", 8);
        chk("j7_sum", 32'(bus.oSUM), 16);
        accept();
        chk("j7_busy_after_ack", 32'(bus.oBUSY), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
